// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 command/response codes and host transmitter state encoding
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    WAIT_IDLE
  } ps2_tx_state_e;

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 clock/data synchronizer with clock falling-edge detect
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [SYNC_STAGES-1:0] clk_pipe_q, clk_pipe_d;
  logic [SYNC_STAGES-1:0] data_pipe_q, data_pipe_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_pipe_d  = {clk_pipe_q[SYNC_STAGES-2:0], ps2_clk_in};
    data_pipe_d = {data_pipe_q[SYNC_STAGES-2:0], ps2_data_in};
    clk_prev_d  = clk_pipe_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_pipe_q  <= '1;
      data_pipe_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_pipe_q  <= clk_pipe_d;
      data_pipe_q <= data_pipe_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_sync  = clk_pipe_q[SYNC_STAGES-1];
  assign data_sync = data_pipe_q[SYNC_STAGES-1];
  assign clk_fe    = clk_prev_q & ~clk_sync;

endmodule

// File: rtl/ps2_host_transmitter.sv
// rtl/ps2_host_transmitter.sv - PS/2 host-to-device command byte transmitter
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d, to_next;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             clk_sync, data_sync, clk_fe;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fe      (clk_fe)
  );

  always_comb begin
    to_next   = to_cnt_q + 1'b1;
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (send && !done_q && !error_q) begin
          shift_d   = data_in;
          parity_d  = ~^data_in;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes low while the clock is still held, so the device never sees a released clock with data high.
        if (inh_cnt_q == INH_DATA) data_oe_d = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          clk_oe_d  = 1'b0;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = REQUEST;
        end
      end
      REQUEST, SHIFT, WAIT_IDLE: begin
        to_cnt_d = to_next;
        if (to_next == TO_LIMIT) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (state_q == REQUEST) begin
          state_d = SHIFT;
        end else if (state_q == SHIFT) begin
          if (clk_fe) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_d = ~shift_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else if (bit_cnt_q == 4'd9) begin
              data_oe_d = 1'b0;
            end else if (!data_sync) begin
              state_d = WAIT_IDLE;
            end else begin
              data_oe_d = 1'b0;
              error_d   = 1'b1;
              busy_d    = 1'b0;
              state_d   = IDLE;
            end
          end
        end else if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb/tb_ps2_host_transmitter.sv - directed bench for ps2_host_transmitter with an open-collector device model
module tb_ps2_host_transmitter;
  import ps2_pkg::*;

  localparam int INH  = 5000;
  localparam int TMO  = 3000;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       send;
  logic       busy, done, error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .send        (send),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (error === 1'b1) n_err++;
    if (done === 1'b1 && error === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_send(input logic [7:0] b);
    data_in = b;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
  endtask

  task automatic wait_release(output int hi);
    int n;
    n  = 0;
    hi = 0;
    while (ps2_clk_oe !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_oe === 1'b1 && hi < 10000) begin
      hi++;
      @(negedge clk);
    end
  endtask

  // Device clocks the frame; data is read just before each clock release (rising edge).
  task automatic dev_frame(input int pulses, input bit ack, output logic [10:0] seen);
    logic [3:0] idx;
    seen = '0;
    cyc(5);
    seen[0] = ps2_data_line;
    for (int p = 1; p <= pulses; p++) begin
      idx = 4'(p);
      dev_clk_low = 1'b1;
      if (p == 11 && ack) dev_data_low = 1'b1;
      cyc(HALF);
      if (p <= 10) seen[idx] = ps2_data_line;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (p != pulses) cyc(HALF);
    end
  endtask

  task automatic ok_xfer(input string tag, input logic [7:0] b, input logic [10:0] exp_frame,
                         output logic [10:0] seen);
    int hi;
    int k;
    start_send(b);
    chk({tag, "_busy_accept"}, 32'(busy), 1);
    wait_release(hi);
    chk({tag, "_inhibit_len"}, hi, INH);
    dev_frame(11, 1'b1, seen);
    chk({tag, "_frame"}, 32'(seen), 32'(exp_frame));
    k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_error_at_done"}, 32'(error), 0);
  endtask

  initial begin
    logic [10:0] seen;
    int          hi;
    int          k;
    int          d0;
    int          e0;

    rst = 1'b1; send = 1'b0; data_in = 8'h00; dev_clk_low = 1'b0; dev_data_low = 1'b0;
    cyc(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    rst = 1'b0;
    cyc(3);

    // 0xED: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = n_done;
    ok_xfer("ed", PS2_CMD_SET_LEDS, 11'h7DA, seen);
    chk("ed_parity", 32'(seen[9]), 1);
    cyc(5);
    chk("ed_done_count", n_done - d0, 1);

    ok_xfer("x07", 8'h07, 11'h40E, seen);
    chk("x07_parity", 32'(seen[9]), 0);
    cyc(5);

    // send raised in the done cycle must be dropped
    ok_xfer("x00", 8'h00, 11'h600, seen);
    chk("x00_parity", 32'(seen[9]), 1);
    data_in = PS2_CMD_RESET;
    send    = 1'b1;
    cyc(1);
    send    = 1'b0;
    cyc(3);
    chk("send_on_done_busy", 32'(busy), 0);
    chk("send_on_done_clk_oe", 32'(ps2_clk_oe), 0);

    // no ACK on the 11th clock
    d0 = n_done; e0 = n_err;
    start_send(PS2_CMD_RESET);
    wait_release(hi);
    dev_frame(11, 1'b0, seen);
    chk("nack_frame", 32'(seen), 32'h7FE);
    cyc(10);
    chk("nack_error_count", n_err - e0, 1);
    chk("nack_done_count", n_done - d0, 0);
    chk("nack_clk_oe", 32'(ps2_clk_oe), 0);
    chk("nack_data_oe", 32'(ps2_data_oe), 0);
    chk("nack_busy", 32'(busy), 0);

    // device never clocks
    d0 = n_done; e0 = n_err;
    start_send(PS2_CMD_ENABLE);
    wait_release(hi);
    k = 0;
    while (error !== 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, TMO);
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 0);
    chk("timeout_data_oe", 32'(ps2_data_oe), 0);
    chk("timeout_busy", 32'(busy), 0);
    cyc(5);
    chk("timeout_error_count", n_err - e0, 1);
    chk("timeout_done_count", n_done - d0, 0);

    // send while busy is ignored, not queued
    d0 = n_done; e0 = n_err;
    start_send(PS2_CMD_SET_LEDS);
    cyc(100);
    data_in = PS2_CMD_RESET; send = 1'b1; cyc(1); send = 1'b0;
    wait_release(hi);
    data_in = PS2_CMD_RESET; send = 1'b1; cyc(1); send = 1'b0;
    dev_frame(11, 1'b1, seen);
    chk("busy_send_frame", 32'(seen), 32'h7DA);
    cyc(200);
    chk("busy_send_done_count", n_done - d0, 1);
    chk("busy_send_error_count", n_err - e0, 0);
    chk("busy_send_idle", 32'(busy), 0);
    chk("busy_send_clk_oe", 32'(ps2_clk_oe), 0);

    // asynchronous reset after the 4th falling edge of 0x00
    start_send(8'h00);
    wait_release(hi);
    dev_frame(4, 1'b0, seen);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_data_oe", 32'(ps2_data_oe), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("arst_data_oe", 32'(ps2_data_oe), 0);
    chk("arst_busy", 32'(busy), 0);
    cyc(3);
    rst = 1'b0;
    cyc(3);
    ok_xfer("f4", PS2_CMD_ENABLE, 11'h5E8, seen);
    cyc(5);

    chk("never_done_and_error", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
